// File: rtl/weight_bram_loader_pkg.sv
// rtl/weight_bram_loader_pkg.sv - shared constants and state encoding for the weight BRAM loader
package weight_bram_loader_pkg;

    localparam int DATA_W_DEF     = 32;
    localparam int W_W_DEF        = 8;
    localparam int BYTES_PER_WORD = DATA_W_DEF / W_W_DEF;
    localparam int CHECKSUM_W     = 16;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_READ   = 3'd1;
    localparam state_t ST_LATCH  = 3'd2;
    localparam state_t ST_STREAM = 3'd3;
    localparam state_t ST_DONE   = 3'd4;

endpackage

// File: rtl/weight_word_serializer.sv
// rtl/weight_word_serializer.sv - holds one BRAM word and streams it out byte by byte, LSB first
module weight_word_serializer #(
    parameter int DATA_W = 32,
    parameter int W_W    = 8,
    parameter int IDX_W  = (DATA_W / W_W > 1) ? $clog2(DATA_W / W_W) : 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load,
    input  logic              stream_en,
    input  logic              clear,
    input  logic [DATA_W-1:0] word_in,
    input  logic              w_ready,
    output logic              w_valid,
    output logic [W_W-1:0]    w_data,
    output logic [IDX_W-1:0]  byte_idx,
    output logic              word_consumed
);

    localparam logic [IDX_W-1:0] LAST_BYTE = IDX_W'(DATA_W / W_W - 1);

    logic [DATA_W-1:0] word_reg_q, word_reg_d;
    logic [IDX_W-1:0]  byte_idx_q, byte_idx_d;
    logic              accept;

    // Valid follows the stream phase only; the byte index advances on each accepted byte
    always_comb begin
        w_valid       = stream_en;
        accept        = stream_en & w_ready;
        word_consumed = accept & (byte_idx_q == LAST_BYTE);
        w_data        = word_reg_q[int'(byte_idx_q) * W_W +: W_W];
        byte_idx      = byte_idx_q;

        word_reg_d = word_reg_q;
        if (load) begin
            word_reg_d = word_in;
        end

        byte_idx_d = byte_idx_q;
        if (clear) begin
            byte_idx_d = '0;
        end else if (accept) begin
            byte_idx_d = word_consumed ? '0 : byte_idx_q + 1'b1;
        end
    end

    // Word and byte-index registers; the word only changes on load, so w_data holds through stalls
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            word_reg_q <= '0;
            byte_idx_q <= '0;
        end else begin
            word_reg_q <= word_reg_d;
            byte_idx_q <= byte_idx_d;
        end
    end

endmodule

// File: rtl/weight_bram_loader.sv
// rtl/weight_bram_loader.sv - drains the weight BRAM s2 port into the weight stream (WEIGHT_BRAM_LOADER_CHECKSUM_EN adds checksum)
module weight_bram_loader
    import weight_bram_loader_pkg::*;
#(
    parameter int ADDR_W    = 2,
    parameter int NUM_WORDS = 4,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int W_W       = W_W_DEF
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_W-1:0]     bram_address,
    output logic                  bram_chipselect,
    output logic                  bram_clken,
    output logic                  bram_write,
    output logic [DATA_W/8-1:0]   bram_byteenable,
    output logic [DATA_W-1:0]     bram_writedata,
    input  logic [DATA_W-1:0]     bram_readdata,
    output logic                  w_valid,
    input  logic                  w_ready,
    output logic [W_W-1:0]        w_data,
    output logic                  w_last
`ifdef WEIGHT_BRAM_LOADER_CHECKSUM_EN
    ,
    output logic [CHECKSUM_W-1:0] checksum
`endif
);

    localparam int               IDX_W     = (DATA_W / W_W > 1) ? $clog2(DATA_W / W_W) : 1;
    localparam logic [IDX_W-1:0] LAST_BYTE = IDX_W'(DATA_W / W_W - 1);
    localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(NUM_WORDS - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] word_idx_q, word_idx_d;
    logic [IDX_W-1:0]  byte_idx;
    logic              word_consumed;

    weight_word_serializer #(
        .DATA_W (DATA_W),
        .W_W    (W_W),
        .IDX_W  (IDX_W)
    ) u_serializer (
        .clk           (clk),
        .reset_n       (reset_n),
        .load          (state_q == ST_LATCH),
        .stream_en     (state_q == ST_STREAM),
        .clear         (state_q == ST_DONE),
        .word_in       (bram_readdata),
        .w_ready       (w_ready),
        .w_valid       (w_valid),
        .w_data        (w_data),
        .byte_idx      (byte_idx),
        .word_consumed (word_consumed)
    );

    // Sequencer: one READ/LATCH pair per word, then stream its bytes, DONE after the last word
    always_comb begin
        state_d    = state_q;
        word_idx_d = word_idx_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_READ;
                    word_idx_d = '0;
                end
            end
            ST_READ:  state_d = ST_LATCH;
            ST_LATCH: state_d = ST_STREAM;
            ST_STREAM: begin
                if (word_consumed) begin
                    if (word_idx_q == LAST_WORD) begin
                        state_d = ST_DONE;
                    end else begin
                        word_idx_d = word_idx_q + 1'b1;
                        state_d    = ST_READ;
                    end
                end
            end
            ST_DONE: begin
                state_d    = ST_IDLE;
                word_idx_d = '0;
            end
            default: begin
                state_d    = ST_IDLE;
                word_idx_d = '0;
            end
        endcase
    end

    // State and word-index registers; reset aborts any load in progress
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            word_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            word_idx_q <= word_idx_d;
        end
    end

    // Status, BRAM s2 port (read-only use) and last-weight flag decoded from state
    always_comb begin
        busy            = (state_q != ST_IDLE);
        done            = (state_q == ST_DONE);
        bram_chipselect = (state_q == ST_READ);
        bram_address    = word_idx_q;
        bram_clken      = 1'b1;
        bram_write      = 1'b0;
        bram_byteenable = '1;
        bram_writedata  = '0;
        w_last          = (word_idx_q == LAST_WORD) & (byte_idx == LAST_BYTE) & w_valid;
    end

`ifdef WEIGHT_BRAM_LOADER_CHECKSUM_EN
    logic [CHECKSUM_W-1:0] checksum_q, checksum_d;

    // Running sum of accepted bytes, restarted by each accepted start and held after done
    always_comb begin
        checksum_d = checksum_q;
        if ((state_q == ST_IDLE) && start) begin
            checksum_d = '0;
        end else if (w_valid && w_ready) begin
            checksum_d = checksum_q + CHECKSUM_W'(w_data);
        end
        checksum = checksum_q;
    end

    // Checksum accumulator register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            checksum_q <= '0;
        end else begin
            checksum_q <= checksum_d;
        end
    end
`endif

endmodule

// File: tb/tb_weight_bram_loader.sv
// tb/tb_weight_bram_loader.sv - directed self-checking bench for weight_bram_loader
module tb_weight_bram_loader;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        busy;
    logic        done;
    logic [1:0]  bram_address;
    logic        bram_chipselect;
    logic        bram_clken;
    logic        bram_write;
    logic [3:0]  bram_byteenable;
    logic [31:0] bram_writedata;
    logic [31:0] bram_readdata;
    logic        w_valid;
    logic        w_ready;
    logic [7:0]  w_data;
    logic        w_last;
`ifdef WEIGHT_BRAM_LOADER_CHECKSUM_EN
    logic [15:0] checksum;
`endif

    weight_bram_loader dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .start           (start),
        .busy            (busy),
        .done            (done),
        .bram_address    (bram_address),
        .bram_chipselect (bram_chipselect),
        .bram_clken      (bram_clken),
        .bram_write      (bram_write),
        .bram_byteenable (bram_byteenable),
        .bram_writedata  (bram_writedata),
        .bram_readdata   (bram_readdata),
        .w_valid         (w_valid),
        .w_ready         (w_ready),
        .w_data          (w_data),
        .w_last          (w_last)
`ifdef WEIGHT_BRAM_LOADER_CHECKSUM_EN
        ,
        .checksum        (checksum)
`endif
    );

    always #5 clk = ~clk;

    // BRAM s2 model: registered address, unregistered output
    logic [31:0] mem [4];
    logic [1:0]  addr_r = 2'd0;
    always @(posedge clk) begin
        if (bram_chipselect && bram_clken && !bram_write) addr_r <= bram_address;
    end
    assign bram_readdata = mem[addr_r];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [7:0] d_seq;
        logic [7:0] d_ff;
        logic       last;
    } vec_t;

    vec_t tbl [16];
    logic pat [4];

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},   32'(busy), 32'd0);
        check({tag, "_done"},   32'(done), 32'd0);
        check({tag, "_valid"},  32'(w_valid), 32'd0);
        check({tag, "_last"},   32'(w_last), 32'd0);
        check({tag, "_data"},   32'(w_data), 32'd0);
        check({tag, "_cs"},     32'(bram_chipselect), 32'd0);
        check({tag, "_addr"},   32'(bram_address), 32'd0);
`ifdef WEIGHT_BRAM_LOADER_CHECKSUM_EN
        check({tag, "_csum"},   32'(checksum), 32'd0);
`endif
    endtask

    // One full load: pulse start, drive ready per mode, score every accepted byte against the table
    task automatic run_load(input bit ff, input bit toggle, input int s1, input int s2, input bit timed);
        int   n = 0;
        int   first_valid = -1;
        int   done_cnt = 0;
        int   done_rel = -1;
        int   cs_err = 0;
        int   stab_err = 0;
        int   wr_err = 0;
        logic prev_hold = 1'b0;
        logic [7:0] prev_data = 8'h00;
        logic r;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int rel = 1; rel <= 300; rel++) begin
            r       = toggle ? pat[rel % 4] : 1'b1;
            w_ready = r;
            start   = (rel == s1) || (rel == s2);
            if (rel == 1) check("busy_after_start", 32'(busy), 32'd1);
            if (w_valid && first_valid < 0) first_valid = rel;
            if (w_valid && bram_chipselect) cs_err++;
            if (bram_write) wr_err++;
            if (prev_hold && (w_data !== prev_data)) stab_err++;
            if (w_valid && n < 16) begin
                check("w_last", 32'(w_last), 32'(tbl[n].last));
                if (r) begin
                    check("w_data", 32'(w_data), 32'(ff ? tbl[n].d_ff : tbl[n].d_seq));
                    n++;
                end
            end
            prev_hold = w_valid && !r;
            prev_data = w_data;
            if (done) begin
                done_cnt++;
                done_rel = rel;
            end
            @(negedge clk);
            if (done_cnt > 0 && rel >= done_rel + 2) break;
        end
        start   = 1'b0;
        w_ready = 1'b1;
        check("byte_count", 32'(n), 32'd16);
        check("done_pulses", 32'(done_cnt), 32'd1);
        check("cs_during_stream", 32'(cs_err), 32'd0);
        check("stall_stability", 32'(stab_err), 32'd0);
        check("bram_write_seen", 32'(wr_err), 32'd0);
        check("busy_after_done", 32'(busy), 32'd0);
        if (timed) begin
            check("first_valid_cycle", 32'(first_valid), 32'd3);
            check("done_cycle", 32'(done_rel), 32'd25);
        end
`ifdef WEIGHT_BRAM_LOADER_CHECKSUM_EN
        check("checksum", 32'(checksum), ff ? 32'h0FF0 : 32'h0088);
`endif
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            tbl[i].d_seq = 8'(i + 1);
            tbl[i].d_ff  = 8'hFF;
            tbl[i].last  = (i == 15);
        end
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
        mem[0] = 32'h04030201;
        mem[1] = 32'h08070605;
        mem[2] = 32'h0C0B0A09;
        mem[3] = 32'h100F0E0D;

        reset_n = 1'b0;
        start   = 1'b0;
        w_ready = 1'b0;
        #1;
        check_reset_outputs("reset");
        check("clken_const", 32'(bram_clken), 32'd1);
        check("byteenable_const", 32'(bram_byteenable), 32'hF);
        check("writedata_const", bram_writedata, 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        w_ready = 1'b1;

        // Ready held high: ordering, timing, checksum
        run_load(1'b0, 1'b0, 0, 0, 1'b1);
        // Ready toggled 1,0,0,1: same bytes, stable data during stalls
        run_load(1'b0, 1'b1, 0, 0, 1'b0);
        // Start during word 2 and during the DONE cycle: both ignored
        run_load(1'b0, 1'b0, 16, 25, 1'b1);

        // Reset while byte 0x06 is stalled
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int rel = 1; rel <= 9; rel++) begin
            w_ready = 1'b1;
            @(negedge clk);
        end
        w_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("pending_valid", 32'(w_valid), 32'd1);
        check("pending_data", 32'(w_data), 32'h06);
`ifdef WEIGHT_BRAM_LOADER_CHECKSUM_EN
        check("pending_csum", 32'(checksum), 32'h000F);
`endif
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        @(negedge clk);
        reset_n = 1'b1;
        w_ready = 1'b1;
        run_load(1'b0, 1'b0, 0, 0, 1'b1);

        // All-ones data, two back-to-back loads: checksum must not accumulate across loads
        for (int i = 0; i < 4; i++) mem[i] = 32'hFFFFFFFF;
        run_load(1'b1, 1'b0, 0, 0, 1'b1);
        run_load(1'b1, 1'b0, 0, 0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
